sc_io_responder: RTL and testbench

- Memory-mapped IO responder on the single-cycle CPU's data bus; the slave end of the lw/sw path the control unit drives through wmem/m2reg.
- Captures and debounces slide switches and push keys.
- Holds LED and 7-segment output registers written by sw.
- Returns read data combinationally in the same cycle, as the single-cycle datapath requires.

---
 rtl/sc_io_pkg.sv | 26 ++
 rtl/sc_io_responder_if.sv | 11 +
 rtl/sc_hex7seg.sv | 32 +++
 rtl/sc_io_responder.sv | 133 +++++++++++++
 tb/tb_sc_io_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/sc_io_pkg.sv
// rtl/sc_io_pkg.sv - shared constants and types for the single-cycle CPU IO responder
package sc_io_pkg;

    localparam logic [7:0] IO_BASE   = 8'h80;

    localparam logic [4:0] OFF_SW    = 5'h00;
    localparam logic [4:0] OFF_KEY   = 5'h01;
    localparam logic [4:0] OFF_KEDGE = 5'h02;
    localparam logic [4:0] OFF_LED   = 5'h04;
    localparam logic [4:0] OFF_HEX   = 5'h05;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_e;

    // IO window is the 128 bytes at IO_BASE; everything above 0xFF is data memory
    function automatic logic in_io_window(input logic [31:0] a);
        return (a[31:8] == 24'd0) && ((a[7:0] & IO_BASE) == IO_BASE);
    endfunction

endpackage

// File: rtl/sc_io_responder_if.sv
// rtl/sc_io_responder_if.sv - CPU data-bus view of the IO responder
interface sc_io_responder_if;
    logic [31:0] addr;
    logic        wmem;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        io_sel;

    modport master (output addr, output wmem, output wdata, input rdata, input io_sel);
    modport slave  (input addr, input wmem, input wdata, output rdata, output io_sel);
endinterface

// File: rtl/sc_hex7seg.sv
// rtl/sc_hex7seg.sv - combinational hex digit to active-low {g,f,e,d,c,b,a} decoder
module sc_hex7seg
    import sc_io_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sc_io_responder.sv
// rtl/sc_io_responder.sv - memory-mapped switches, keys, LEDs and 7-seg scanner for the CPU data bus
module sc_io_responder
    import sc_io_pkg::*;
#(
    parameter int DB_LIMIT = 16,
    parameter int SCAN_DIV = 4
) (
    input  logic               clock,
    input  logic               reset,
    sc_io_responder_if.slave   bus,
    input  logic [9:0]         sw,
    input  logic [3:0]         key,
    output logic [9:0]         led,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    localparam int DBW = $clog2(DB_LIMIT);
    localparam int DVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_LIMIT - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(SCAN_DIV - 1);

    logic [9:0]     sw_s1_q, sw_s2_q, sw_db_q, sw_db_d;
    logic [DBW-1:0] sw_cnt_q, sw_cnt_d;
    logic [3:0]     key_s1_q, key_s2_q, key_db_q, key_db_d;
    logic [DBW-1:0] key_cnt_q, key_cnt_d;
    logic [3:0]     kedge_q, kedge_d;
    logic [9:0]     led_q, led_d;
    logic [15:0]    hex_q, hex_d;
    logic [DVW-1:0] div_q, div_d;
    digit_e         dig_q, dig_d;

    logic [4:0]  off;
    logic        wr_en;
    logic [3:0]  key_pressed;
    logic [3:0]  digit_nib;
    logic        unused_bits;

    assign bus.io_sel  = in_io_window(bus.addr);
    assign off         = bus.addr[6:2];
    assign wr_en       = bus.wmem & bus.io_sel;
    assign key_pressed = ~key_s2_q;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:16]};

    // Debounce: a group updates only after DB_LIMIT consecutive cycles of disagreement
    always_comb begin
        sw_db_d   = sw_db_q;
        sw_cnt_d  = '0;
        key_db_d  = key_db_q;
        key_cnt_d = '0;
        if (sw_s2_q != sw_db_q) begin
            if (sw_cnt_q == DB_LAST) sw_db_d  = sw_s2_q;
            else                     sw_cnt_d = sw_cnt_q + 1'b1;
        end
        if (key_pressed != key_db_q) begin
            if (key_cnt_q == DB_LAST) key_db_d  = key_pressed;
            else                      key_cnt_d = key_cnt_q + 1'b1;
        end
    end

    // Register writes; a new press wins over a same-cycle W1C clear
    always_comb begin
        led_d   = led_q;
        hex_d   = hex_q;
        kedge_d = kedge_q;
        if (wr_en && off == OFF_LED)   led_d   = bus.wdata[9:0];
        if (wr_en && off == OFF_HEX)   hex_d   = bus.wdata[15:0];
        if (wr_en && off == OFF_KEDGE) kedge_d = kedge_q & ~bus.wdata[3:0];
        kedge_d = kedge_d | (key_db_d & ~key_db_q);
    end

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        dig_d = dig_q;
        if (div_q == DIV_LAST) dig_d = digit_e'(dig_q + 2'd1);
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.io_sel) begin
            case (off)
                OFF_SW:    bus.rdata = {22'd0, sw_db_q};
                OFF_KEY:   bus.rdata = {28'd0, key_db_q};
                OFF_KEDGE: bus.rdata = {28'd0, kedge_q};
                OFF_LED:   bus.rdata = {22'd0, led_q};
                OFF_HEX:   bus.rdata = {16'd0, hex_q};
                default:   bus.rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            key_s1_q  <= 4'hF;
            key_s2_q  <= 4'hF;
            sw_db_q   <= '0;
            sw_cnt_q  <= '0;
            key_db_q  <= '0;
            key_cnt_q <= '0;
            kedge_q   <= '0;
            led_q     <= '0;
            hex_q     <= '0;
            div_q     <= '0;
            dig_q     <= DIG0;
        end else begin
            sw_s1_q   <= sw;
            sw_s2_q   <= sw_s1_q;
            key_s1_q  <= key;
            key_s2_q  <= key_s1_q;
            sw_db_q   <= sw_db_d;
            sw_cnt_q  <= sw_cnt_d;
            key_db_q  <= key_db_d;
            key_cnt_q <= key_cnt_d;
            kedge_q   <= kedge_d;
            led_q     <= led_d;
            hex_q     <= hex_d;
            div_q     <= div_d;
            dig_q     <= dig_d;
        end
    end

    assign digit_nib = hex_q[{dig_q, 2'b00} +: 4];
    assign an        = ~(4'b0001 << dig_q);
    assign led       = led_q;

    sc_hex7seg u_hex7seg (
        .hex_i (digit_nib),
        .seg_o (seg)
    );

endmodule

// File: tb/tb_sc_io_responder.sv
// tb/tb_sc_io_responder.sv - randomized bench with a behavioural model of the IO responder
module tb_sc_io_responder;

    localparam int DB_LIMIT = 16;
    localparam int SCAN_DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] sw    = '0;
    logic [3:0] key   = 4'hF;
    logic [9:0] led;
    logic [6:0] seg;
    logic [3:0] an;

    sc_io_responder_if bus();

    sc_io_responder #(.DB_LIMIT(DB_LIMIT), .SCAN_DIV(SCAN_DIV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .sw    (sw),
        .key   (key),
        .led   (led),
        .seg   (seg),
        .an    (an)
    );

    initial forever #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: state after each rising edge
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [9:0]  m_sw_s1, m_sw_s2, m_sw_db;
    logic [3:0]  m_key_s1, m_key_s2, m_key_db, m_kedge;
    logic [9:0]  m_led;
    logic [15:0] m_hex;
    int          m_sw_run, m_key_run, m_ticks;
    bit          m_valid = 1'b0;

    function automatic bit m_sel(input logic [31:0] a);
        return (a < 32'h100) && (a >= 32'h80);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        if (!m_sel(a)) return 32'd0;
        case (a[6:2])
            5'd0:    return {22'd0, m_sw_db};
            5'd1:    return {28'd0, m_key_db};
            5'd2:    return {28'd0, m_kedge};
            5'd4:    return {22'd0, m_led};
            5'd5:    return {16'd0, m_hex};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] old_kdb, clr;
        bit         wr;
        if (reset) begin
            m_sw_s1 = '0; m_sw_s2 = '0; m_sw_db = '0; m_sw_run = 0;
            m_key_s1 = 4'hF; m_key_s2 = 4'hF; m_key_db = '0; m_key_run = 0;
            m_kedge = '0; m_led = '0; m_hex = '0; m_ticks = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_sw_s2 != m_sw_db) begin
                m_sw_run++;
                if (m_sw_run == DB_LIMIT) begin m_sw_db = m_sw_s2; m_sw_run = 0; end
            end else m_sw_run = 0;
            old_kdb = m_key_db;
            if (~m_key_s2 != m_key_db) begin
                m_key_run++;
                if (m_key_run == DB_LIMIT) begin m_key_db = ~m_key_s2; m_key_run = 0; end
            end else m_key_run = 0;
            wr  = bus.wmem && m_sel(bus.addr);
            clr = (wr && bus.addr[6:2] == 5'd2) ? bus.wdata[3:0] : 4'h0;
            m_kedge = (m_kedge & ~clr) | (m_key_db & ~old_kdb);
            if (wr && bus.addr[6:2] == 5'd4) m_led = bus.wdata[9:0];
            if (wr && bus.addr[6:2] == 5'd5) m_hex = bus.wdata[15:0];
            m_sw_s2 = m_sw_s1;   m_sw_s1 = sw;
            m_key_s2 = m_key_s1; m_key_s1 = key;
            m_ticks++;
        end
    endtask

    // Compare process: outputs settle after the rising edge, checked on the falling edge
    initial forever begin
        int idx;
        @(negedge clock);
        model_step();
        if (m_valid) begin
            idx = (m_ticks / SCAN_DIV) % 4;
            chk("led",    32'(led),        32'(m_led));
            chk("an",     32'(an),         32'(4'hF & ~(4'b0001 << idx)));
            chk("seg",    32'(seg),        32'(glyph[(m_hex >> (4 * idx)) & 16'hF]));
            chk("io_sel", 32'(bus.io_sel), 32'(m_sel(bus.addr)));
            chk("rdata",  bus.rdata,       m_rdata(bus.addr));
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.wmem = 1'b1;
        tick();
        bus.wmem = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(name, bus.rdata, exp);
    endtask

    initial begin
        int sw_hold, key_hold;
        bus.addr = '0; bus.wdata = '0; bus.wmem = 1'b0;
        ticks(3);
        reset = 1'b0;
        rd("rst_led", 32'h90, 32'h0);
        rd("rst_hex", 32'h94, 32'h0);
        rd("rst_kedge", 32'h88, 32'h0);
        chk("rst_an", 32'(an), 32'hE);
        chk("rst_seg", 32'(seg), 32'h40);

        wr(32'h94, 32'h0000_1A2F);
        chk("scan0_an", 32'(an), 32'hE); chk("scan0_seg", 32'(seg), 32'h0E);
        ticks(3);
        chk("scan1_an", 32'(an), 32'hD); chk("scan1_seg", 32'(seg), 32'h24);
        ticks(4);
        chk("scan2_an", 32'(an), 32'hB); chk("scan2_seg", 32'(seg), 32'h08);
        ticks(4);
        chk("scan3_an", 32'(an), 32'h7); chk("scan3_seg", 32'(seg), 32'h79);
        ticks(4);
        chk("scan4_an", 32'(an), 32'hE); chk("scan4_seg", 32'(seg), 32'h0E);

        sw = 10'h2A5;
        ticks(17);
        rd("sw_early", 32'h80, 32'h0);
        tick();
        rd("sw_cycle18", 32'h80, 32'h2A5);
        sw = 10'h000; ticks(5); sw = 10'h2A5; ticks(25);
        rd("sw_glitch", 32'h80, 32'h2A5);

        key = 4'b1011; ticks(30);
        rd("key_press", 32'h84, 32'h4);
        rd("kedge_press", 32'h88, 32'h4);
        key = 4'hF; ticks(30);
        rd("key_release", 32'h84, 32'h0);
        rd("kedge_sticky", 32'h88, 32'h4);
        wr(32'h88, 32'h4);
        rd("kedge_w1c", 32'h88, 32'h0);

        wr(32'h90, 32'hFFFF_F3FF);
        chk("led_write", 32'(led), 32'h3FF);
        rd("led_read", 32'h90, 32'h3FF);
        wr(32'h1000_0090, 32'h0);
        chk("led_outside", 32'(led), 32'h3FF);
        rd("rdata_outside", 32'h1000_0090, 32'h0);
        chk("io_sel_outside", 32'(bus.io_sel), 32'h0);

        reset = 1'b1; bus.addr = 32'h90; bus.wdata = 32'h1; bus.wmem = 1'b1;
        tick();
        reset = 1'b0; bus.wmem = 1'b0;
        chk("rst_wmem_led", 32'(led), 32'h0);
        wr(32'h9C, 32'hFFFF_FFFF);
        rd("unmapped", 32'h9C, 32'h0);
        chk("unmapped_led", 32'(led), 32'h0);
        rd("unmapped_hex", 32'h94, 32'h0);

        sw_hold = 0; key_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (sw_hold == 0) begin sw = 10'($urandom); sw_hold = $urandom_range(1, 40); end
            else sw_hold--;
            if (key_hold == 0) begin key = 4'($urandom); key_hold = $urandom_range(1, 40); end
            else key_hold--;
            case ($urandom_range(0, 9))
                8:       bus.addr = $urandom;
                9:       bus.addr = {24'd0, 1'b0, 7'($urandom)};
                default: bus.addr = {24'd0, 1'b1, 5'($urandom_range(0, 7)), 2'($urandom)};
            endcase
            bus.wdata = $urandom;
            bus.wmem  = ($urandom_range(0, 2) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; bus.wmem = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
